// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and helpers for the MAC partial-sum drain
package mac_pkg;

    localparam int NF = 20;
    localparam int PW = 22;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int IW = 5;
    localparam int CW = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    // A programmed pass count of zero behaves as a single pass.
    function automatic logic [CW-1:0] norm_pass(input logic [CW-1:0] n);
        return (n == '0) ? CW'(1) : n;
    endfunction

endpackage

// File: rtl/mac_act_quant.sv
// rtl/mac_act_quant.sv - combinational ReLU, arithmetic right shift and signed saturation to OW bits
module mac_act_quant
    import mac_pkg::*;
(
    input  logic signed [AW-1:0] acc_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    output logic signed [OW-1:0] q_o
);

    localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(OW-1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [AW-1:0] relu_v;
    logic signed [AW-1:0] shr_v;

    always_comb begin
        relu_v = (relu_en_i && acc_i[AW-1]) ? '0 : acc_i;
        shr_v  = relu_v >>> shift_i;
        if (shr_v > SAT_MAX) begin
            q_o = SAT_MAX[OW-1:0];
        end else if (shr_v < SAT_MIN) begin
            q_o = SAT_MIN[OW-1:0];
        end else begin
            q_o = shr_v[OW-1:0];
        end
    end

endmodule

// File: rtl/mac_psum_drain.sv
// rtl/mac_psum_drain.sv - per-lane multi-pass partial-sum accumulation and serialized quantized drain
module mac_psum_drain
    import mac_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [NF-1:0]      psum_vld,
    input  logic [NF*PW-1:0]   psum,
    input  logic [CW-1:0]      num_pass,
    input  logic [4:0]         shift,
    input  logic               relu_en,
    output logic               acc_rdy,
    output logic [OW-1:0]      dout,
    output logic [IW-1:0]      dout_idx,
    output logic               dout_vld,
    input  logic               dout_rdy,
    output logic               tile_done,
    output logic               ovf_err,
    input  logic               clr_err
);

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q [NF];
    logic signed [AW-1:0] acc_d [NF];
    logic [CW-1:0]        cnt_q [NF];
    logic [CW-1:0]        cnt_d [NF];
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        np_q, np_d;
    logic [4:0]           shift_q, shift_d;
    logic                 relu_q, relu_d;
    logic                 tile_done_q, tile_done_d;
    logic                 ovf_q, ovf_d;

    logic                 all_zero;
    logic                 all_full;
    logic                 drop;
    logic [CW-1:0]        np_eff;
    logic signed [OW-1:0] quant_q;

    // The first sample of a tile is judged against the pass count being latched in that same cycle.
    always_comb begin
        all_zero = 1'b1;
        for (int f = 0; f < NF; f++) begin
            if (cnt_q[f] != '0) begin
                all_zero = 1'b0;
            end
        end
        np_eff = (state_q == COLLECT && all_zero) ? norm_pass(num_pass) : np_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        np_d        = np_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        tile_done_d = 1'b0;
        drop        = 1'b0;
        all_full    = 1'b1;

        case (state_q)
            COLLECT: begin
                if (all_zero) begin
                    np_d    = norm_pass(num_pass);
                    shift_d = shift;
                    relu_d  = relu_en;
                end
                for (int f = 0; f < NF; f++) begin
                    if (psum_vld[f]) begin
                        if (cnt_q[f] < np_eff) begin
                            acc_d[f] = acc_q[f] +
                                {{(AW-PW){psum[f*PW+PW-1]}}, psum[f*PW +: PW]};
                            cnt_d[f] = cnt_q[f] + CW'(1);
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    if (cnt_d[f] != np_eff) begin
                        all_full = 1'b0;
                    end
                end
                if (all_full) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (|psum_vld) begin
                    drop = 1'b1;
                end
                if (dout_rdy) begin
                    if (idx_q == IW'(NF-1)) begin
                        for (int f = 0; f < NF; f++) begin
                            acc_d[f] = '0;
                            cnt_d[f] = '0;
                        end
                        idx_d       = '0;
                        state_d     = COLLECT;
                        tile_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase

        ovf_d = drop | (ovf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= COLLECT;
            for (int f = 0; f < NF; f++) begin
                acc_q[f] <= '0;
                cnt_q[f] <= '0;
            end
            idx_q       <= '0;
            np_q        <= CW'(1);
            shift_q     <= '0;
            relu_q      <= 1'b0;
            tile_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            np_q        <= np_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            tile_done_q <= tile_done_d;
            ovf_q       <= ovf_d;
        end
    end

    mac_act_quant u_quant (
        .acc_i     (acc_q[idx_q]),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .q_o       (quant_q)
    );

    assign acc_rdy   = (state_q == COLLECT);
    assign dout_vld  = (state_q == DRAIN);
    assign dout      = dout_vld ? quant_q : '0;
    assign dout_idx  = idx_q;
    assign tile_done = tile_done_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mac_psum_drain.sv
// tb/tb_mac_psum_drain.sv - directed and randomized tiles scored against a tile-level reference model
module tb_mac_psum_drain;
    import mac_pkg::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NF-1:0]    psum_vld;
    logic [NF*PW-1:0] psum;
    logic [7:0]       num_pass;
    logic [4:0]       shift;
    logic             relu_en;
    logic             acc_rdy;
    logic [OW-1:0]    dout;
    logic [4:0]       dout_idx;
    logic             dout_vld;
    logic             dout_rdy;
    logic             tile_done;
    logic             ovf_err;
    logic             clr_err;

    always #5 clk = ~clk;

    mac_psum_drain dut (
        .clk       (clk),
        .rstn      (rstn),
        .psum_vld  (psum_vld),
        .psum      (psum),
        .num_pass  (num_pass),
        .shift     (shift),
        .relu_en   (relu_en),
        .acc_rdy   (acc_rdy),
        .dout      (dout),
        .dout_idx  (dout_idx),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .tile_done (tile_done),
        .ovf_err   (ovf_err),
        .clr_err   (clr_err)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     vals [NF];
    longint m_acc [NF];
    int     m_cnt [NF];
    int     m_np   = 1;
    int     m_sh   = 0;
    bit     m_relu = 1'b0;
    bit     m_drain = 1'b0;
    bit     m_ovf   = 1'b0;

    localparam logic [NF-1:0] ALL = {NF{1'b1}};

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: ReLU, floor division by 2^shift, clamp to the signed OW range.
    function automatic longint exp_q(input longint a, input int sh, input bit relu);
        longint v, d, q;
        v = (relu && a < 0) ? 0 : a;
        d = longint'(1) << sh;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic int pass_of(input logic [7:0] n);
        return (n == 0) ? 1 : int'(n);
    endfunction

    task automatic model_clear(input bit also_ovf);
        for (int f = 0; f < NF; f++) begin
            m_acc[f] = 0;
            m_cnt[f] = 0;
        end
        m_drain = 1'b0;
        if (also_ovf) m_ovf = 1'b0;
    endtask

    task automatic step(input logic [NF-1:0] mask, input bit clr);
        bit drop, allz, full;
        check("phase_vld", dout_vld, m_drain);
        check("phase_rdy", acc_rdy, !m_drain);
        check("ovf_err", ovf_err, m_ovf);
        psum_vld = mask;
        clr_err  = clr;
        for (int f = 0; f < NF; f++) psum[f*PW +: PW] = vals[f][PW-1:0];
        drop = 1'b0;
        if (m_drain) begin
            drop = |mask;
        end else begin
            allz = 1'b1;
            for (int f = 0; f < NF; f++) if (m_cnt[f] != 0) allz = 1'b0;
            if (allz) begin
                m_np = pass_of(num_pass);
                m_sh = int'(shift);
                m_relu = relu_en;
            end
            full = 1'b1;
            for (int f = 0; f < NF; f++) begin
                if (mask[f]) begin
                    if (m_cnt[f] < m_np) begin
                        m_acc[f] += longint'(vals[f]);
                        m_cnt[f]++;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (m_cnt[f] != m_np) full = 1'b0;
            end
            m_drain = full;
        end
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(negedge clk);
        psum_vld = '0;
        clr_err  = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic drain(input int mode, input int lim);
        int beats, cyc;
        bit rdy;
        beats = 0;
        cyc = 0;
        while (beats < lim) begin
            if (cyc >= 300) begin
                check("drain_timeout", cyc, 0);
                break;
            end
            check("dout_vld", dout_vld, 1);
            check("dout_idx", dout_idx, beats);
            check("dout", $signed(dout), exp_q(m_acc[beats], m_sh, m_relu));
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3 == 0);
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            dout_rdy = rdy;
            @(negedge clk);
            if (rdy) beats++;
            cyc++;
        end
        dout_rdy = 1'b0;
        if (lim == NF && beats == NF) begin
            check("tile_done", tile_done, 1);
            check("post_vld", dout_vld, 0);
            check("post_rdy", acc_rdy, 1);
            model_clear(1'b0);
        end
    endtask

    task automatic uniform_tile(input int np, input int sh, input bit relu, input int v, input int mode);
        num_pass = 8'(np);
        shift    = 5'(sh);
        relu_en  = relu;
        for (int f = 0; f < NF; f++) vals[f] = v;
        repeat (pass_of(8'(np))) step(ALL, 1'b0);
        drain(mode, NF);
    endtask

    task automatic rand_vals();
        for (int f = 0; f < NF; f++) begin
            if ($urandom_range(0, 1) == 1) vals[f] = int'($urandom_range(0, 600)) - 300;
            else vals[f] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
        end
    endtask

    task automatic rand_tile();
        int cyc, np_now;
        bit allz;
        logic [NF-1:0] mask;
        num_pass = 8'($urandom_range(0, 4));
        shift    = 5'($urandom_range(0, 12));
        relu_en  = $urandom_range(0, 1) == 1;
        cyc = 0;
        while (!m_drain) begin
            if (cyc >= 400) begin
                check("collect_timeout", cyc, 0);
                break;
            end
            allz = 1'b1;
            for (int f = 0; f < NF; f++) if (m_cnt[f] != 0) allz = 1'b0;
            np_now = allz ? pass_of(num_pass) : m_np;
            rand_vals();
            mask = '0;
            for (int f = 0; f < NF; f++)
                if (m_cnt[f] < np_now && $urandom_range(0, 2) == 0) mask[f] = 1'b1;
            if (allz && mask == '0) mask[$urandom_range(0, NF - 1)] = 1'b1;
            step(mask, 1'b0);
            num_pass = 8'($urandom_range(0, 255));
            shift    = 5'($urandom_range(0, 31));
            relu_en  = $urandom_range(0, 1) == 1;
            cyc++;
        end
        drain(2, NF);
    endtask

    initial begin
        rstn     = 1'b0;
        psum_vld = '0;
        psum     = '0;
        num_pass = 8'd1;
        shift    = '0;
        relu_en  = 1'b0;
        dout_rdy = 1'b0;
        clr_err  = 1'b0;
        model_clear(1'b1);
        repeat (2) @(negedge clk);
        check("rst_acc_rdy", acc_rdy, 1);
        check("rst_dout", dout, 0);
        check("rst_dout_idx", dout_idx, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_ovf_err", ovf_err, 0);
        rstn = 1'b1;
        @(negedge clk);

        num_pass = 8'd1;
        shift    = 5'd0;
        relu_en  = 1'b0;
        for (int f = 0; f < NF; f++) vals[f] = f - 10;
        step(ALL, 1'b0);
        drain(0, NF);

        num_pass = 8'd3;
        shift    = 5'd4;
        for (int f = 0; f < NF; f++) vals[f] = 1000;
        for (int c = 0; c < 70; c++) begin
            logic [NF-1:0] mask;
            mask = '0;
            for (int f = 0; f < NF; f++)
                if (c == f || c == f + 25 || c == f + 50) mask[f] = 1'b1;
            step(mask, 1'b0);
        end
        drain(0, NF);

        uniform_tile(2, 0, 1'b1, -2097152, 0);
        uniform_tile(2, 20, 1'b0, -2097152, 0);
        uniform_tile(2, 0, 1'b0, -2097152, 0);
        uniform_tile(0, 3, 1'b0, 777, 0);

        num_pass = 8'd2;
        shift    = 5'd2;
        relu_en  = 1'b0;
        rand_vals();
        step(ALL, 1'b0);
        rand_vals();
        step(ALL, 1'b0);
        drain(1, NF);

        num_pass = 8'd1;
        shift    = 5'd1;
        rand_vals();
        step(ALL & ~(NF'(1) << 19), 1'b0);
        step(NF'(1) << 5, 1'b0);
        step(NF'(1) << 19, 1'b0);
        step(NF'(1), 1'b0);
        drain(0, NF);
        step('0, 1'b1);
        step(NF'(1) << 3, 1'b0);
        step(NF'(1) << 3, 1'b1);
        step('0, 1'b1);
        step(ALL & ~(NF'(1) << 3), 1'b0);
        drain(2, NF);

        num_pass = 8'd1;
        shift    = 5'd0;
        rand_vals();
        step(ALL, 1'b0);
        drain(2, 8);
        rstn = 1'b0;
        #1;
        check("rst_mid_vld", dout_vld, 0);
        check("rst_mid_rdy", acc_rdy, 1);
        check("rst_mid_idx", dout_idx, 0);
        check("rst_mid_done", tile_done, 0);
        model_clear(1'b1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        uniform_tile(1, 0, 1'b0, 5, 0);

        repeat (6) rand_tile();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
